// File: rtl/pcpi_vec_pkg.sv
// pcpi_vec_pkg: shared constants, FSM/op enums and instruction decoder for the vector coprocessor
package pcpi_vec_pkg;
  localparam int VLEN = 128;
  localparam int VLMAX = VLEN / 32;
  localparam int EW = $clog2(VLMAX);
  localparam logic [6:0] OPC_V = 7'b1010111;
  localparam logic [6:0] OPC_LD = 7'b0000111;
  localparam logic [6:0] OPC_ST = 7'b0100111;
  localparam logic [2:0] F3_SET = 3'b111;
  localparam logic [2:0] F3_IVV = 3'b000;
  localparam logic [2:0] W_32 = 3'b111;
  localparam logic [5:0] F6_ADD = 6'b000000;
  localparam logic [5:0] F6_MUL = 6'b100101;
  localparam logic [5:0] F6_DOT = 6'b111001;
  localparam logic [1:0] MOP_UNIT = 2'b00;
  localparam logic [1:0] MOP_STRIDE = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_SETVL, S_MEM_REQ, S_MEM_WAIT, S_ARITH, S_DONE} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_SETVL, OP_LOAD, OP_STORE, OP_ADD, OP_MUL, OP_DOT} op_e;
  function automatic op_e decode(input logic [31:0] i);
    logic mem_ok, arith;
    mem_ok = i[14:12] == W_32 && (i[27:26] == MOP_UNIT || i[27:26] == MOP_STRIDE);
    arith = i[6:0] == OPC_V && i[14:12] == F3_IVV;
    return (i[6:0] == OPC_V && i[14:12] == F3_SET && !i[31]) ? OP_SETVL :
           (i[6:0] == OPC_LD && mem_ok) ? OP_LOAD :
           (i[6:0] == OPC_ST && mem_ok) ? OP_STORE :
           (arith && i[31:26] == F6_ADD) ? OP_ADD :
           (arith && i[31:26] == F6_MUL) ? OP_MUL :
           (arith && i[31:26] == F6_DOT) ? OP_DOT : OP_NONE;
  endfunction
endpackage

// File: rtl/pcpi_vec_if.sv
// pcpi_vec_if: PCPI instruction port plus 32-bit memory master bundle
//  slave  = coprocessor side (takes instructions, masters memory)
//  master = CPU/memory side
interface pcpi_vec_if;
  logic pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready, mem_valid, mem_ready;
  logic [31:0] pcpi_insn, pcpi_cpurs1, pcpi_cpurs2, pcpi_rd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  modport slave (
    input pcpi_valid, pcpi_insn, pcpi_cpurs1, pcpi_cpurs2, mem_ready, mem_rdata,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_cpurs1, pcpi_cpurs2, mem_ready, mem_rdata,
    input pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/vec_regfile.sv
// vec_regfile: 32 x VLEN vector registers, element-indexed, 2 async read ports, 1 element write port
//  we/wreg/widx/wdata  write one 32-bit element
//  ra/rb/ridx          read element ridx of registers ra and rb
module vec_regfile
  import pcpi_vec_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [4:0]    wreg,
  input  logic [EW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [4:0]    ra,
  input  logic [4:0]    rb,
  input  logic [EW-1:0] ridx,
  output logic [31:0]   rdata_a,
  output logic [31:0]   rdata_b
);
  logic [31:0] regs [32][VLMAX];
  always_ff @(posedge clk)
    if (we) regs[wreg][widx] <= wdata;
  assign rdata_a = regs[ra][ridx];
  assign rdata_b = regs[rb][ridx];
endmodule

// File: rtl/pcpi_vec_coproc.sv
// pcpi_vec_coproc: PCPI vector coprocessor (vsetvli, unit/strided load/store, vadd/vmul/vdot)
//  clk, reset  clock and asynchronous active-high reset
//  bus         pcpi_vec_if.slave: PCPI handshake in, memory master out
module pcpi_vec_coproc
  import pcpi_vec_pkg::*;
(
  input logic clk,
  input logic reset,
  pcpi_vec_if.slave bus
);
  state_e st;
  op_e op, dec;
  logic [4:0] vd, vs1, vs2;
  logic [31:0] stride, prod, rd_a, rd_b, mul, wdata;
  logic [EW:0] vl, idx, new_vl;
  logic [10:0] vtype;
  logic phase, step, last, we, unused;
  assign dec = decode(bus.pcpi_insn);
  assign new_vl = bus.pcpi_insn[24:22] != 3'b010 ? '0 :
                  bus.pcpi_cpurs1 < 32'(VLMAX) ? bus.pcpi_cpurs1[EW:0] : (EW+1)'(VLMAX);
  assign last = idx + 1'b1 == vl;
  // vdot needs vd as a third operand: phase 0 multiplies, phase 1 reads vd and accumulates
  assign step = op != OP_DOT || phase;
  assign mul = rd_a * rd_b;
  assign we = (st == S_MEM_WAIT && bus.mem_ready && op == OP_LOAD) ||
              (st == S_ARITH && vl != '0 && step);
  assign wdata = st == S_MEM_WAIT ? bus.mem_rdata : op == OP_ADD ? rd_a + rd_b :
                 op == OP_MUL ? mul : rd_a + prod;
  assign unused = ^vtype;
  vec_regfile u_rf (
    .clk(clk), .we(we), .wreg(vd), .widx(idx[EW-1:0]), .wdata(wdata),
    .ra(phase || op == OP_STORE ? vd : vs2), .rb(vs1), .ridx(idx[EW-1:0]),
    .rdata_a(rd_a), .rdata_b(rd_b)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= S_IDLE;
      op <= OP_NONE;
      vd <= '0;
      vs1 <= '0;
      vs2 <= '0;
      stride <= '0;
      prod <= '0;
      vl <= '0;
      idx <= '0;
      vtype <= '0;
      phase <= 1'b0;
      bus.pcpi_wr <= 1'b0;
      bus.pcpi_rd <= '0;
      bus.pcpi_wait <= 1'b0;
      bus.pcpi_ready <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else
      case (st)
        S_IDLE: if (bus.pcpi_valid && dec != OP_NONE) begin
          op <= dec;
          vd <= bus.pcpi_insn[11:7];
          vs1 <= bus.pcpi_insn[19:15];
          vs2 <= bus.pcpi_insn[24:20];
          idx <= '0;
          phase <= 1'b0;
          bus.pcpi_wait <= 1'b1;
          st <= dec == OP_SETVL ? S_SETVL : (dec == OP_LOAD || dec == OP_STORE) ? S_MEM_REQ : S_ARITH;
          if (dec == OP_SETVL) begin
            vtype <= bus.pcpi_insn[30:20];
            vl <= new_vl;
            bus.pcpi_rd <= 32'(new_vl);
          end
          if (dec == OP_LOAD || dec == OP_STORE) begin
            bus.mem_addr <= bus.pcpi_cpurs1;
            bus.mem_wstrb <= dec == OP_STORE ? 4'b1111 : 4'b0000;
            stride <= bus.pcpi_insn[27:26] == MOP_STRIDE ? bus.pcpi_cpurs2 : 32'd4;
          end
        end
        S_SETVL: begin
          bus.pcpi_ready <= 1'b1;
          bus.pcpi_wr <= 1'b1;
          st <= S_DONE;
        end
        S_MEM_REQ: if (vl == '0) begin
          bus.pcpi_ready <= 1'b1;
          st <= S_DONE;
        end else begin
          bus.mem_valid <= 1'b1;
          bus.mem_wdata <= rd_a;
          st <= S_MEM_WAIT;
        end
        S_MEM_WAIT: if (bus.mem_ready) begin
          bus.mem_valid <= 1'b0;
          bus.mem_addr <= bus.mem_addr + stride;
          idx <= idx + 1'b1;
          bus.pcpi_ready <= last;
          st <= last ? S_DONE : S_MEM_REQ;
        end
        S_ARITH: begin
          phase <= !step && vl != '0;
          if (!step) prod <= mul;
          if (step) idx <= idx + 1'b1;
          if (vl == '0 || (step && last)) begin
            bus.pcpi_ready <= 1'b1;
            st <= S_DONE;
          end
        end
        S_DONE: begin
          bus.pcpi_ready <= 1'b0;
          bus.pcpi_wr <= 1'b0;
          bus.pcpi_wait <= 1'b0;
          st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
endmodule

// File: tb/tb_pcpi_vec_coproc.sv
// tb_pcpi_vec_coproc: directed, table-driven bench for pcpi_vec_coproc with a word memory model
module tb_pcpi_vec_coproc;
  localparam logic [10:0] E32 = 11'h008;
  localparam logic [10:0] E8 = 11'h000;
  localparam logic [5:0] ADD = 6'b000000, MUL = 6'b100101, DOT = 6'b111001;
  typedef struct { logic [10:0] vt; logic [31:0] avl; logic [31:0] rd; } sv_t;
  typedef struct { logic [31:0] addr; logic [31:0] val; } mv_t;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
  int total = 0, passed = 0, reqs = 0, writes = 0, bad_strb = 0;
  logic [31:0] mem [1024];
  logic [31:0] last_rd;
  logic last_wr;
  int last_cyc;
  sv_t sv_tab[7];
  mv_t mv_tab[22];
  pcpi_vec_if bus();
  pcpi_vec_coproc dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus.mem_ready = bus.mem_valid && !bus.mem_ready && !stall;
    if (bus.mem_ready) begin
      reqs++;
      bus.mem_rdata = mem[bus.mem_addr[11:2]];
      if (bus.mem_wstrb == 4'hf) begin
        mem[bus.mem_addr[11:2]] = bus.mem_wdata;
        writes++;
      end else if (bus.mem_wstrb != 4'h0) bad_strb++;
    end
  end

  function automatic logic [31:0] vset(input logic [10:0] vt);
    return {1'b0, vt, 5'd1, 3'b111, 5'd5, 7'b1010111};
  endfunction
  function automatic logic [31:0] vmem(input logic is_st, input logic [4:0] v, input logic [1:0] mop);
    return {3'b000, 1'b0, mop, 1'b1, 5'd2, 5'd1, 3'b111, v, is_st ? 7'b0100111 : 7'b0000111};
  endfunction
  function automatic logic [31:0] varith(input logic [5:0] f6, input logic [4:0] vd, vs2, vs1);
    return {f6, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic op(input string name, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    int cyc = 0;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn = insn;
    bus.pcpi_cpurs1 = a;
    bus.pcpi_cpurs2 = b;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.pcpi_ready && cyc < 100);
    chk({name, " ready+wait"}, {bus.pcpi_ready, bus.pcpi_wait}, 2'b11);
    last_rd = bus.pcpi_rd;
    last_wr = bus.pcpi_wr;
    last_cyc = cyc;
    bus.pcpi_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, r0;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn = '0;
    bus.pcpi_cpurs1 = '0;
    bus.pcpi_cpurs2 = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5555_5555;
    for (int i = 0; i < 9; i++) mem[400/4 + i] = 32'(i + 1);
    mem[440/4] = 10; mem[444/4] = 20; mem[448/4] = 30;
    for (int i = 0; i < 4; i++) mem[600/4 + i] = 32'(101 + i);
    mem[500/4] = 32'hFFFF_FFFF; mem[504/4] = 2; mem[508/4] = 3;
    mem[520/4] = 1; mem[524/4] = 3; mem[528/4] = 4;
    mem[900/4] = 0;
    mem[812/4] = 32'h0000_CAFE;
    sv_tab = '{'{E32, 32'd3, 32'd3}, '{E32, 32'd10, 32'd4}, '{E8, 32'd5, 32'd0},
               '{E32, 32'd0, 32'd0}, '{E32, 32'd4, 32'd4}, '{11'h004, 32'd2, 32'd0},
               '{11'h00B, 32'd10, 32'd4}};
    mv_tab = '{'{700, 1}, '{704, 4}, '{708, 7}, '{712, 104},
               '{720, 10}, '{724, 10}, '{728, 10}, '{732, 32'h5555_5555},
               '{800, 140}, '{804, 320}, '{808, 500}, '{812, 32'h0000_CAFE},
               '{840, 0}, '{844, 5}, '{848, 7}, '{852, 32'h5555_5555},
               '{860, 32'hFFFF_FFFF}, '{864, 6}, '{868, 12},
               '{880, 0}, '{884, 5}, '{888, 7}};
    repeat (3) @(negedge clk);
    chk("reset ctrl outs", {bus.pcpi_wr, bus.pcpi_wait, bus.pcpi_ready, bus.mem_valid, bus.mem_wstrb}, 0);
    chk("reset data outs", bus.pcpi_rd | bus.mem_addr | bus.mem_wdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      op($sformatf("vsetvli[%0d]", i), vset(sv_tab[i].vt), sv_tab[i].avl, 0);
      chk($sformatf("vsetvli[%0d] rd", i), last_rd, sv_tab[i].rd);
      chk($sformatf("vsetvli[%0d] wr", i), 32'(last_wr), 1);
      chk($sformatf("vsetvli[%0d] latency", i), last_cyc, 2);
    end
    op("vset4", vset(E32), 4, 0);
    op("vle v1", vmem(0, 1, 2'b00), 600, 0);
    op("vset3", vset(E32), 3, 0);
    op("vlse v1", vmem(0, 1, 2'b10), 400, 12);
    op("vset4", vset(E32), 4, 0);
    w0 = writes;
    op("vse v1", vmem(1, 1, 2'b00), 700, 0);
    chk("vse v1 writes", writes - w0, 4);
    op("vset3", vset(E32), 3, 0);
    op("vlse v4 bcast", vmem(0, 4, 2'b10), 440, 0);
    op("vse v4", vmem(1, 4, 2'b00), 720, 0);
    op("zero v8", vmem(0, 8, 2'b10), 900, 0);
    op("vlse v2", vmem(0, 2, 2'b10), 404, 12);
    op("vlse v3", vmem(0, 3, 2'b10), 408, 12);
    for (int k = 0; k < 3; k++) begin
      op("bcast v4", vmem(0, 4, 2'b10), 32'(440 + 4 * k), 0);
      op("vdot", varith(DOT, 8, 4, 5'(1 + k)), 0, 0);
    end
    w0 = writes;
    op("vse v8", vmem(1, 8, 2'b00), 800, 0);
    chk("vse v8 writes", writes - w0, 3);
    op("vle v10", vmem(0, 10, 2'b00), 500, 0);
    op("vle v11", vmem(0, 11, 2'b00), 520, 0);
    op("vadd", varith(ADD, 12, 10, 11), 0, 0);
    op("vmul", varith(MUL, 13, 10, 11), 0, 0);
    op("vse v12", vmem(1, 12, 2'b00), 840, 0);
    op("vse v13", vmem(1, 13, 2'b00), 860, 0);
    op("vadd vd=vs2", varith(ADD, 10, 10, 11), 0, 0);
    op("vse v10", vmem(1, 10, 2'b00), 880, 0);
    op("vset e8", vset(E8), 5, 0);
    r0 = reqs;
    op("vle vl0", vmem(0, 1, 2'b00), 400, 0);
    chk("vl0 load traffic", reqs - r0, 0);
    chk("vl0 load latency", last_cyc, 2);
    op("vadd vl0", varith(ADD, 1, 2, 3), 0, 0);
    chk("vl0 vadd latency", last_cyc, 2);
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn = varith(6'b000001, 1, 2, 3);
    repeat (6) @(negedge clk);
    chk("unknown insn ignored", {bus.pcpi_wait, bus.pcpi_ready, bus.mem_valid}, 0);
    bus.pcpi_valid = 1'b0;
    op("vset3 pre-reset", vset(E32), 3, 0);
    stall = 1'b1;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn = vmem(0, 20, 2'b00);
    bus.pcpi_cpurs1 = 400;
    n = 0;
    while (!bus.mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("load in flight", {bus.mem_valid, bus.pcpi_wait}, 2'b11);
    reset = 1'b1;
    #1;
    chk("reset mid-op outs", {bus.mem_valid, bus.pcpi_wait, bus.pcpi_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.pcpi_valid = 1'b0;
    stall = 1'b0;
    op("vset after reset", vset(E32), 2, 0);
    chk("vset after reset rd", last_rd, 2);
    chk("vset after reset latency", last_cyc, 2);
    for (int i = 0; i < 22; i++)
      chk($sformatf("mem@%0d", mv_tab[i].addr), mem[mv_tab[i].addr[11:2]], mv_tab[i].val);
    chk("bad wstrb count", bad_strb, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
